// File: rtl/sprite_motion_if.sv
// Control inputs and position/event outputs of the sprite motion controller.
interface sprite_motion_if;
  logic        vsync;
  logic        enable;
  logic        pause;
  logic [9:0]  spriteX;
  logic [8:0]  spriteY;
  logic        frameTick;
  logic        bounce;
  logic        cornerHit;
  logic [15:0] frameCount;

  modport master (output vsync, enable, pause,
                  input  spriteX, spriteY, frameTick, bounce, cornerHit, frameCount);
  modport slave  (input  vsync, enable, pause,
                  output spriteX, spriteY, frameTick, bounce, cornerHit, frameCount);
endinterface

// File: rtl/sprite_motion_controller.sv
// Bouncing-sprite position generator: one step per vsync falling edge while RUN,
// reflecting off the screen edges.
module sprite_motion_controller #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int SPEED    = 2,
  parameter int START_X  = 100,
  parameter int START_Y  = 100
) (
  input  logic            real100clock,
  input  logic            rst_n,
  sprite_motion_if.slave  bus
);
  localparam logic [10:0] MAXX = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] MAXY = 11'(SCREEN_H - SPRITE_H);
  localparam logic [10:0] SPD  = 11'(SPEED);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state_q, state_d;
  logic        vs1_q, vs2_q, vs_prev_q;
  logic [1:0]  rdy_q;
  logic        armed_q, armed_d;
  logic        evt_q, evt_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic        tick_q, tick_d, bounce_q, bounce_d, corner_q, corner_d;
  logic [15:0] fc_q, fc_d;
  logic [10:0] xw, yw, xs, ys;
  logic        rx, ry;

  // The edge detector only arms once a genuine high level has reached the
  // second sync flop after reset, so a vsync held low through reset is not
  // mistaken for a falling edge.
  always_comb begin
    armed_d = armed_q | (rdy_q[1] & vs2_q);
    evt_d   = armed_q & vs_prev_q & ~vs2_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.enable) state_d = RUN;
      RUN:     if (!bus.enable) state_d = IDLE; else if (bus.pause) state_d = HOLD;
      HOLD:    if (!bus.enable) state_d = IDLE; else if (!bus.pause) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    fc_d     = fc_q;
    tick_d   = 1'b0;
    bounce_d = 1'b0;
    corner_d = 1'b0;
    rx       = 1'b0;
    ry       = 1'b0;
    xw       = {1'b0, x_q};
    yw       = {2'b0, y_q};
    xs       = xw;
    ys       = yw;
    if (evt_q && state_q == RUN) begin
      // 11-bit math so x+SPEED never wraps before the limit compare
      if (dx_q) begin
        if (xw + SPD >= MAXX) begin xs = MAXX; dx_d = 1'b0; rx = 1'b1; end
        else xs = xw + SPD;
      end else begin
        if (xw <= SPD) begin xs = '0; dx_d = 1'b1; rx = 1'b1; end
        else xs = xw - SPD;
      end
      if (dy_q) begin
        if (yw + SPD >= MAXY) begin ys = MAXY; dy_d = 1'b0; ry = 1'b1; end
        else ys = yw + SPD;
      end else begin
        if (yw <= SPD) begin ys = '0; dy_d = 1'b1; ry = 1'b1; end
        else ys = yw - SPD;
      end
      x_d      = xs[9:0];
      y_d      = ys[8:0];
      fc_d     = fc_q + 16'd1;
      tick_d   = 1'b1;
      bounce_d = rx | ry;
      corner_d = rx & ry;
    end
  end

  always_ff @(posedge real100clock or negedge rst_n) begin
    if (!rst_n) begin
      vs1_q     <= 1'b1;
      vs2_q     <= 1'b1;
      vs_prev_q <= 1'b1;
      rdy_q     <= 2'b00;
      armed_q   <= 1'b0;
      evt_q     <= 1'b0;
      state_q   <= IDLE;
      x_q       <= 10'(START_X);
      y_q       <= 9'(START_Y);
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      fc_q      <= '0;
      tick_q    <= 1'b0;
      bounce_q  <= 1'b0;
      corner_q  <= 1'b0;
    end else begin
      vs1_q     <= bus.vsync;
      vs2_q     <= vs1_q;
      vs_prev_q <= vs2_q;
      rdy_q     <= {rdy_q[0], 1'b1};
      armed_q   <= armed_d;
      evt_q     <= evt_d;
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      fc_q      <= fc_d;
      tick_q    <= tick_d;
      bounce_q  <= bounce_d;
      corner_q  <= corner_d;
    end
  end

  assign bus.spriteX    = x_q;
  assign bus.spriteY    = y_q;
  assign bus.frameTick  = tick_q;
  assign bus.bounce     = bounce_q;
  assign bus.cornerHit  = corner_q;
  assign bus.frameCount = fc_q;
endmodule

// File: doc/sprite_motion_controller.md
SPRITE_MOTION_CONTROLLER -- requirements
Module: sprite_motion_controller

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- SCREEN_W, 640, active pixels per line.
- SCREEN_H, 480, active lines per frame.
- SPRITE_W, 32, sprite width in pixels.
- SPRITE_H, 32, sprite height in pixels.
- SPEED, 2, pixels moved per axis per frame (1..15).
- START_X, 100, reset X position.
- START_Y, 100, reset Y position.

REQ-002 Ports, one per line: name, direction, width, meaning.
- real100clock, in, 1, sole clock; all flops on its rising edge.
- rst_n, in, 1, reset; asynchronous and active-low.
- vsync, in, 1, active-low vertical sync from the VGA timing driver; asynchronous to internal logic.
- enable, in, 1, level; 1 = motion permitted.
- pause, in, 1, level; 1 = freeze position while running.
- spriteX, out, 10, sprite left edge fed to the drawing controller.
- spriteY, out, 9, sprite top edge fed to the drawing controller.
- frameTick, out, 1, one-cycle pulse on every position-update edge.
- bounce, out, 1, one-cycle pulse when any axis reflected this frame.
- cornerHit, out, 1, one-cycle pulse when both axes reflected in the same frame.
- frameCount, out, 16, count of frame ticks taken in RUN; wraps 0xFFFF -> 0.

Function
REQ-003 vsync SHALL pass through a 2-flop synchroniser; a frame event is a 1->0 transition of the second flop, registered once more (3 rising edges from first low sample).
- vsync held low for any duration SHALL produce exactly one frame event.
REQ-004 FSM states: IDLE, RUN, HOLD.
- IDLE -> RUN when enable=1.
- RUN -> HOLD when pause=1.
- HOLD -> RUN when pause=0.
- RUN or HOLD -> IDLE when enable=0; evaluated on every clock.
REQ-005 Position, direction and frameCount SHALL change only on the clock edge where the frame event is high and state is RUN.
- In IDLE/HOLD, frame events SHALL be ignored: no frameTick, no count.
REQ-006 Limits: MAXX = SCREEN_W-SPRITE_W (608 default); MAXY = SCREEN_H-SPRITE_H (448).
- Internal arithmetic SHALL be 11-bit unsigned with no truncation before compare.
REQ-007 X update, direction dx:
- dx=+: if x+SPEED >= MAXX then x=MAXX, dx=-, X reflects; else x=x+SPEED.
- dx=-: if x <= SPEED then x=0, dx=+, X reflects; else x=x-SPEED.
REQ-008 Y SHALL follow REQ-007 identically with dy, MAXY and spriteY.
REQ-009 frameTick SHALL pulse high for one cycle on each update edge.
- bounce SHALL be high on that same edge when X or Y reflects.
- cornerHit SHALL be high on that same edge only when X and Y both reflect.
- All three SHALL be 0 on every other cycle.
REQ-010 frameCount SHALL increment by 1 on each update edge.
REQ-011 spriteX/spriteY SHALL be driven directly from registers, stable between update edges. Updates occur only in vertical blank, so there is no tearing.
REQ-012 Re-entering RUN from HOLD or IDLE SHALL resume from the retained position, direction and count; no re-initialisation.

Reset
REQ-013 While rst_n=0, asynchronously:
- state=IDLE.
- spriteX=START_X, spriteY=START_Y.
- dx=+, dy=+.
- frameTick=0, bounce=0, cornerHit=0, frameCount=0.
- Synchroniser flops=1 (vsync idle level).
REQ-014 Reset asserted mid-frame or mid-update SHALL abort immediately to REQ-013 values.
- After release, the first frame event SHALL require a fresh vsync falling edge.

Verification
REQ-015 Reset, then enable=1, one vsync low pulse -> exactly one frameTick; spriteX=102, spriteY=102, frameCount=1, bounce=0.
REQ-016 Right-edge reflection: force X to 606 with dx=+ and Y at 200, one frame -> spriteX=608, bounce=1, cornerHit=0. Next frame -> spriteX=606.
REQ-017 Corner: X=607/dx=+ and Y=447/dy=+, one frame -> spriteX=608, spriteY=448, bounce=1, cornerHit=1.
REQ-018 Hold vsync low for 1000 cycles -> single frameTick. Then pause=1 for 3 vsync pulses -> no frameTick, position and count unchanged.
REQ-019 Assert rst_n=0 on the frame-event cycle -> outputs equal REQ-013 values with no update applied. enable=0 during vsync pulses -> state IDLE, outputs frozen.
